memory_arbiter: RTL

Shares the single main-memory port between the instruction cache and the data cache in `Top`. Each cache issues a line-transfer request (read refill or write-back) of `BURST_LEN` words. The arbiter grants one requester at a time, sequences the word-by-word burst on the memory port and returns read data and beat/completion strobes. It sits between `InstruktionCache`/`DatenCache` and the shared RAM.

---
 rtl/memory_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - I/D cache arbiter and burst sequencer for the shared memory port
// Optional feature: define MEMORY_ARBITER_DCACHE_PRIO_EN for fixed D-cache priority (default: round-robin).
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int BEAT_W     = $clog2(BURST_LEN)
) (
  input  logic                  clk_25mhz,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  i_gnt,
  output logic                  i_valid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic [BEAT_W-1:0]     beat,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DONE} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    own_q, own_d;       // burst owner: 1 = data cache
  logic                    i_valid_q, i_valid_d;
  logic                    d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic                    pick_d;             // arbitration result: data cache wins
  logic                    final_ack;

  assign final_ack = (state_q == ST_BURST) && mem_ack && (beat_q == LAST_BEAT);

`ifdef MEMORY_ARBITER_DCACHE_PRIO_EN
  // Fixed priority: the data cache always wins a tie.
  always_comb pick_d = d_req;
`else
  logic last_q, last_d;                        // 1 = data cache was granted last

  // Round-robin: on a tie the requester not granted last wins.
  always_comb pick_d = d_req && (!i_req || !last_q);

  // Remember the owner of each completed burst.
  always_comb begin
    last_d = last_q;
    if (final_ack) last_d = own_q;
  end

  // Round-robin history register; resets to D so I wins the first tie.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      own_q     <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      own_q     <= own_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state: grant in IDLE, step beats on ack in BURST, single DONE cycle.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    we_d      = we_q;
    addr_d    = addr_q;
    own_d     = own_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          own_d   = pick_d;
          we_d    = pick_d ? d_we : i_we;
          addr_d  = pick_d ? d_addr : i_addr;
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (mem_ack) begin
          if (own_q) begin
            d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_valid_d = 1'b1;
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req   = (state_q == ST_BURST);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? (addr_q + ADDR_WIDTH'(beat_q)) : '0;
  assign mem_wdata = !mem_req ? '0 : (own_q ? d_wdata : i_wdata);
  assign beat      = beat_q;
  assign i_gnt     = (state_q != ST_IDLE) && !own_q;
  assign d_gnt     = (state_q != ST_IDLE) && own_q;
  assign i_done    = (state_q == ST_DONE) && !own_q;
  assign d_done    = (state_q == ST_DONE) && own_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
